// File: rtl/result_queue_arbiter.sv
// Round-robin arbiter that lets NUM_REQ burst producers share one result-queue
// write port through a single registered output stage.
module result_queue_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rq_we,
   output logic [WIDTH-1:0]           rq_data,
   input  logic                       rq_full,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int unsigned GW = $clog2(NUM_REQ);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [GW-1:0]     grant_id_q, grant_id_d;
   logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;

   logic              sel_found;
   logic [GW-1:0]     sel_idx;
   logic [GW-1:0]     cand;
   logic              stage_free;
   logic              accept;
   logic [WIDTH-1:0]  gnt_data;
   logic              gnt_last;

   // First valid requester searching upward from rr_ptr+1, wrapping at NUM_REQ.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Output-stage handshake; a drain and a reload may happen in the same cycle.
   always_comb begin
      rq_we      = out_valid_q & ~rq_full;
      stage_free = ~out_valid_q | rq_we;
      gnt_data   = req_data[32'(grant_id_q)*WIDTH +: WIDTH];
      gnt_last   = req_last[grant_id_q];
      accept     = (state_q == S_BURST) & req_valid[grant_id_q] & stage_free;
      req_ready  = '0;
      if (state_q == S_BURST) begin
         req_ready[grant_id_q] = stage_free;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               grant_id_d = sel_idx;
               state_d    = S_BURST;
            end
         end
         S_BURST: begin
            if (accept && gnt_last) begin
               state_d  = S_IDLE;
               rr_ptr_d = grant_id_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
      end else if (rq_we) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         grant_id_q  <= '0;
         rr_ptr_q    <= GW'(NUM_REQ - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign rq_data  = out_data_q;
   assign grant_id = grant_id_q;
   assign busy     = (state_q == S_BURST) | out_valid_q;

endmodule

// File: tb/tb_result_queue_arbiter.sv
// Scoreboard bench: burst-level round-robin model predicts write order and grant owners.
module tb_result_queue_arbiter;

   localparam int NR = 4;
   localparam int W  = 32;

   logic              clk = 1'b0;
   logic              resetn;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_last;
   logic [NR*W-1:0]   req_data;
   logic [NR-1:0]     req_ready;
   logic              rq_we;
   logic [W-1:0]      rq_data;
   logic              rq_full;
   logic [1:0]        grant_id;
   logic              busy;

   result_queue_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
      .req_data(req_data), .req_ready(req_ready), .rq_we(rq_we), .rq_data(rq_data),
      .rq_full(rq_full), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int rr_model;

   logic [W-1:0] pdata [NR][64];
   logic         plast [NR][64];
   int           pcnt  [NR];
   int           pptr  [NR];

   logic [W-1:0] sb_q[$];
   int           owner_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write must match the head of the expected stream.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         chk("ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
         if (rq_we === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual=%0h required=none", rq_data);
            end else begin
               chk("rq_data", 64'(rq_data), 64'(sb_q.pop_front()));
            end
         end
      end
   end

   task automatic clear_all();
      for (int i = 0; i < NR; i++) begin
         pcnt[i] = 0;
         pptr[i] = 0;
      end
   endtask

   task automatic load_burst(input int p, input int len);
      for (int b = 0; b < len; b++) begin
         pdata[p][pcnt[p]] = {8'(p), 24'($urandom)};
         plast[p][pcnt[p]] = (b == len - 1);
         pcnt[p]++;
      end
   endtask

   // Whole bursts, round-robin from the last winner, among producers with work left.
   task automatic predict();
      int idx[NR];
      int rr, found;
      bit l;
      for (int i = 0; i < NR; i++) idx[i] = 0;
      rr = rr_model;
      forever begin
         found = -1;
         for (int k = 1; k <= NR; k++)
            if (found < 0 && idx[(rr + k) % NR] < pcnt[(rr + k) % NR]) found = (rr + k) % NR;
         if (found < 0) break;
         owner_q.push_back(found);
         do begin
            sb_q.push_back(pdata[found][idx[found]]);
            l = plast[found][idx[found]];
            idx[found]++;
         end while (!l);
         rr = found;
      end
      rr_model = rr;
   endtask

   // Runs loaded traffic to completion; called and returns at posedge+1.
   task automatic run_traffic(input int full_pct, input bit stall_on);
      logic [NR-1:0] acc;
      bit pend, mid, stall;
      int cyc;
      predict();
      acc = '0;
      cyc = 0;
      do begin
         pend = 1'b0;
         for (int i = 0; i < NR; i++) begin
            if (acc[i]) pptr[i]++;
            mid   = (pptr[i] > 0) && (pptr[i] < pcnt[i]) && !plast[i][pptr[i] - 1];
            stall = stall_on && mid && ($urandom_range(2) == 0);
            if (pptr[i] < pcnt[i]) begin
               pend = 1'b1;
               req_valid[i]       = !stall;
               req_data[i*W +: W] = pdata[i][pptr[i]];
               req_last[i]        = plast[i][pptr[i]];
            end else begin
               req_valid[i]       = 1'b0;
               req_data[i*W +: W] = $urandom;
               req_last[i]        = 1'($urandom);
            end
         end
         rq_full = ($urandom_range(99) < 32'(full_pct));
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            acc[i] = req_valid[i] & req_ready[i];
            if (acc[i]) begin
               if (owner_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL extra_accept actual=%0d required=none", i);
               end else begin
                  chk("grant_owner", 64'(i), 64'(owner_q[0]));
                  chk("grant_id", 64'(grant_id), 64'(i));
                  if (plast[i][pptr[i]]) void'(owner_q.pop_front());
               end
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end while ((pend || sb_q.size() != 0) && cyc < 3000);
      if (cyc >= 3000) begin
         checks++;
         failures++;
         $display("FAIL traffic_timeout actual=%0d required=0 pending beats", sb_q.size());
         sb_q.delete();
      end
      chk("owners_left", 64'(owner_q.size()), 64'(0));
      owner_q.delete();
      req_valid = '0;
      req_last  = '0;
      rq_full   = 1'b0;
      clear_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn    = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      rq_full   = 1'b0;
      clear_all();
      rr_model  = NR - 1;
      #1;
      chk("rst_rq_we", 64'(rq_we), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_grant", 64'(grant_id), 64'(0));
      chk("rst_rq_data", 64'(rq_data), 64'(0));
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // All four single-beat, producer 0 twice: 0,1,2,3,0.
      for (int p = 0; p < NR; p++) load_burst(p, 1);
      load_burst(0, 1);
      run_traffic(0, 1'b0);

      // Single request latency with data 0xA5.
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      req_data[W +: W] = 32'hA5;
      sb_q.push_back(32'hA5);
      @(negedge clk);
      chk("lat_idle_busy", 64'(busy), 64'(0));
      chk("lat_idle_ready", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat_grant", 64'(grant_id), 64'(1));
      chk("lat_ready", 64'(req_ready), 64'(4'b0010));
      chk("lat_no_we", 64'(rq_we), 64'(0));
      @(posedge clk); #1;
      req_valid = '0;
      req_last  = '0;
      @(negedge clk);
      chk("lat_we", 64'(rq_we), 64'(1));
      chk("lat_data", 64'(rq_data), 64'(32'hA5));
      chk("lat_idle_again", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("lat_done_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      rr_model = 1;

      // Burst lock: 4 beats from 2 while 0 waits, then 0.
      load_burst(2, 4);
      load_burst(0, 1);
      run_traffic(0, 1'b0);

      // Backpressure heavy.
      load_burst(1, 3);
      load_burst(3, 2);
      run_traffic(60, 1'b0);

      // Source stalls mid-burst.
      load_burst(1, 5);
      load_burst(3, 2);
      load_burst(0, 1);
      run_traffic(0, 1'b1);

      // Randomized mixes.
      for (int it = 0; it < 15; it++) begin
         for (int p = 0; p < NR; p++) begin
            int nb;
            nb = $urandom_range(3);
            for (int b = 0; b < nb; b++) load_burst(p, $urandom_range(5, 1));
         end
         run_traffic($urandom_range(50), 1'b1);
      end

      // Reset mid-burst: first beat written, second discarded in the stage.
      req_valid = 4'b0100;
      req_last  = '0;
      req_data[2*W +: W] = 32'hD0;
      sb_q.push_back(32'hD0);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rmb_ready", 64'(req_ready), 64'(4'b0100));
      @(posedge clk); #1;
      req_data[2*W +: W] = 32'hD1;
      @(negedge clk);
      chk("rmb_we", 64'(rq_we), 64'(1));
      chk("rmb_data", 64'(rq_data), 64'(32'hD0));
      @(posedge clk); #1;
      req_data[2*W +: W] = 32'hD2;
      #1;
      resetn = 1'b0;
      #1;
      chk("rmb_rst_we", 64'(rq_we), 64'(0));
      chk("rmb_rst_ready", 64'(req_ready), 64'(0));
      chk("rmb_rst_busy", 64'(busy), 64'(0));
      chk("rmb_rst_grant", 64'(grant_id), 64'(0));
      chk("rmb_rst_data", 64'(rq_data), 64'(0));
      req_valid = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      rr_model = NR - 1;
      chk("rmb_sb_empty", 64'(sb_q.size()), 64'(0));
      load_burst(3, 1);
      load_burst(0, 1);
      run_traffic(0, 1'b0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
